alu_serial_ctrl: RTL and testbench

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

---
 rtl/alu_serial_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer for an external 1-bit ALU slice.
// An operation is fed to the slice LSB first, one bit per RUN cycle; the
// result is assembled from the slice outputs and presented with a one-cycle
// Done pulse together with Carry/Overflow/Zero/Error flags.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH    = 16,
    parameter logic [2:0]  CTRL_AND = 3'b000,
    parameter logic [2:0]  CTRL_OR  = 3'b010,
    parameter logic [2:0]  CTRL_XOR = 3'b011,
    parameter logic [2:0]  CTRL_ADD = 3'b001,
    parameter logic [2:0]  CTRL_SUB = 3'b110
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       OpCode,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             SliceA,
    output logic             SliceB,
    output logic             SliceCIN,
    output logic             SliceBInvert,
    output logic             SliceLess,
    output logic [2:0]       SliceCtrl,
    input  logic             SliceRez,
    input  logic             SliceCout,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero,
    output logic             Error
);

    localparam int unsigned    CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-2:0] r_a;        // operand bits not yet presented to the slice
    logic [WIDTH-2:0] r_b;
    logic [WIDTH-2:0] r_acc;      // result bits collected so far, shifted in at the top

    logic             r_slice_a;
    logic             r_slice_b;
    logic             r_slice_cin;
    logic             r_slice_binv;
    logic [2:0]       r_slice_ctrl;

    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;
    logic             r_error;

    logic             w_legal;
    logic             w_sub;
    logic [2:0]       w_ctrl;
    logic             w_arith;
    logic             w_slt;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res_fin;
    logic             w_carry_fin;
    logic             w_ovf_fin;

    // Decode the incoming opcode into legality and slice configuration
    always_comb begin
        w_legal = 1'b1;
        w_sub   = 1'b0;
        w_ctrl  = CTRL_AND;
        case (OpCode)
            OP_AND: w_ctrl = CTRL_AND;
            OP_OR:  w_ctrl = CTRL_OR;
            OP_XOR: w_ctrl = CTRL_XOR;
            OP_ADD: w_ctrl = CTRL_ADD;
            OP_SUB, OP_SLT: begin
                w_ctrl = CTRL_SUB;
                w_sub  = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Form the final result and flags from the last slice cycle
    always_comb begin
        w_arith     = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_SLT);
        w_slt       = (r_op == OP_SLT);
        w_sum       = {SliceRez, r_acc};
        w_ovf       = SliceCout ^ r_slice_cin;
        w_res_fin   = w_sum;
        w_carry_fin = w_arith & SliceCout;
        w_ovf_fin   = w_arith & w_ovf;
        if (w_slt) begin
            // Signed less-than: sign of the difference corrected by overflow.
            w_res_fin    = '0;
            w_res_fin[0] = SliceRez ^ w_ovf;
            w_carry_fin  = 1'b0;
            w_ovf_fin    = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_nxt = w_legal ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, per-bit slice sequencing and result/flag update
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_cnt        <= '0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_slice_a    <= 1'b0;
            r_slice_b    <= 1'b0;
            r_slice_cin  <= 1'b0;
            r_slice_binv <= 1'b0;
            r_slice_ctrl <= '0;
            r_result     <= '0;
            r_carry      <= 1'b0;
            r_ovf        <= 1'b0;
            r_zero       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        if (w_legal) begin
                            r_op         <= OpCode;
                            r_cnt        <= '0;
                            r_error      <= 1'b0;
                            r_a          <= OpA[WIDTH-1:1];
                            r_b          <= OpB[WIDTH-1:1];
                            r_slice_a    <= OpA[0];
                            r_slice_b    <= OpB[0];
                            r_slice_cin  <= w_sub;
                            r_slice_binv <= w_sub;
                            r_slice_ctrl <= w_ctrl;
                        end else begin
                            r_result <= '0;
                            r_carry  <= 1'b0;
                            r_ovf    <= 1'b0;
                            r_zero   <= 1'b1;
                            r_error  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_sum[WIDTH-1:1];
                    if (r_cnt == LAST) begin
                        r_result     <= w_res_fin;
                        r_carry      <= w_carry_fin;
                        r_ovf        <= w_ovf_fin;
                        r_zero       <= (w_res_fin == '0);
                        r_slice_a    <= 1'b0;
                        r_slice_b    <= 1'b0;
                        r_slice_cin  <= 1'b0;
                        r_slice_binv <= 1'b0;
                        r_slice_ctrl <= '0;
                    end else begin
                        r_cnt       <= r_cnt + 1'b1;
                        r_slice_a   <= r_a[0];
                        r_slice_b   <= r_b[0];
                        r_a         <= r_a >> 1;
                        r_b         <= r_b >> 1;
                        r_slice_cin <= SliceCout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SliceA       = r_slice_a;
    assign SliceB       = r_slice_b;
    assign SliceCIN     = r_slice_cin;
    assign SliceBInvert = r_slice_binv;
    assign SliceLess    = 1'b0;
    assign SliceCtrl    = r_slice_ctrl;
    assign Busy         = (r_state == S_RUN);
    assign Done         = (r_state == S_DONE);
    assign Result       = r_result;
    assign Carry        = r_carry;
    assign Overflow     = r_ovf;
    assign Zero         = r_zero;
    assign Error        = r_error;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: drives directed and random operations through a
// behavioural 1-bit ALU slice and compares against an arithmetic model.
module tb_alu_serial_ctrl;

    localparam int W = 16;

    logic          Clock;
    logic          Reset;
    logic          Start;
    logic [2:0]    OpCode;
    logic [W-1:0]  OpA;
    logic [W-1:0]  OpB;
    logic          SliceA;
    logic          SliceB;
    logic          SliceCIN;
    logic          SliceBInvert;
    logic          SliceLess;
    logic [2:0]    SliceCtrl;
    logic          SliceRez;
    logic          SliceCout;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  Result;
    logic          Carry;
    logic          Overflow;
    logic          Zero;
    logic          Error;

    int n_tests = 0;
    int n_fail  = 0;

    alu_serial_ctrl #(
        .WIDTH    (W),
        .CTRL_AND (3'b000),
        .CTRL_OR  (3'b010),
        .CTRL_XOR (3'b011),
        .CTRL_ADD (3'b001),
        .CTRL_SUB (3'b110)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .OpCode       (OpCode),
        .OpA          (OpA),
        .OpB          (OpB),
        .SliceA       (SliceA),
        .SliceB       (SliceB),
        .SliceCIN     (SliceCIN),
        .SliceBInvert (SliceBInvert),
        .SliceLess    (SliceLess),
        .SliceCtrl    (SliceCtrl),
        .SliceRez     (SliceRez),
        .SliceCout    (SliceCout),
        .Busy         (Busy),
        .Done         (Done),
        .Result       (Result),
        .Carry        (Carry),
        .Overflow     (Overflow),
        .Zero         (Zero),
        .Error        (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural 1-bit ALU slice
    logic w_bb;
    always_comb begin
        w_bb      = SliceB ^ SliceBInvert;
        SliceCout = (SliceA & w_bb) | (SliceCIN & (SliceA ^ w_bb));
        case (SliceCtrl)
            3'b000:  SliceRez = SliceA & w_bb;
            3'b010:  SliceRez = SliceA | w_bb;
            3'b011:  SliceRez = SliceA ^ w_bb;
            default: SliceRez = SliceA ^ w_bb ^ SliceCIN;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: result and flags from plain arithmetic on the operands
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic c, output logic v,
                         output logic err, output logic [2:0] ctrl, output logic sub);
        logic [W:0] s;
        res = '0; c = 1'b0; v = 1'b0; err = 1'b0; ctrl = 3'b000; sub = 1'b0;
        case (op)
            3'b000: res = a & b;
            3'b001: begin res = a | b; ctrl = 3'b010; end
            3'b011: begin res = a ^ b; ctrl = 3'b011; end
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                res = s[W-1:0]; c = s[W]; ctrl = 3'b001;
                v = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            3'b110: begin
                s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                res = s[W-1:0]; c = s[W]; ctrl = 3'b110; sub = 1'b1;
                v = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            3'b111: begin
                res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
                ctrl = 3'b110; sub = 1'b1;
            end
            default: err = 1'b1;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold);
        logic [W-1:0] e_res;
        logic         e_c, e_v, e_err, sub;
        logic [2:0]   e_ctrl;
        logic [W-1:0] bp;
        logic [31:0]  part;
        logic [31:0]  mask;
        int n, busy_n, slice_err, k;
        logic cin0_obs, binv0_obs;
        model(op, a, b, e_res, e_c, e_v, e_err, e_ctrl, sub);
        bp = sub ? ~b : b;
        cin0_obs = 1'b0; binv0_obs = 1'b0;
        @(negedge Clock);
        Start = 1'b1; OpCode = op; OpA = a; OpB = b;
        @(posedge Clock); #1;
        if (!hold) Start = 1'b0;
        n = 0; busy_n = 0; slice_err = 0;
        while (!Done && n < W + 8) begin
            if (Busy) begin
                k = busy_n;
                if (k == 0) begin cin0_obs = SliceCIN; binv0_obs = SliceBInvert; end
                mask = (32'd1 << k) - 32'd1;
                part = (32'(a) & mask) + (32'(bp) & mask) + 32'(sub);
                if (k < W) begin
                    if (SliceA !== a[k]) slice_err++;
                    if (SliceB !== b[k]) slice_err++;
                    if (SliceCIN !== part[k]) slice_err++;
                end else begin
                    slice_err++;
                end
                if (SliceBInvert !== sub) slice_err++;
                if (SliceCtrl !== e_ctrl) slice_err++;
                busy_n++;
            end
            if (hold) begin
                OpA = W'($urandom); OpB = W'($urandom); OpCode = 3'($urandom);
            end
            @(posedge Clock); #1;
            n++;
        end
        Start = 1'b0;
        check("latency", 32'(n), e_err ? 32'd0 : 32'(W));
        check("busy_cycles", 32'(busy_n), e_err ? 32'd0 : 32'(W));
        check("done", 32'(Done), 32'd1);
        check("result", 32'(Result), 32'(e_res));
        check("carry", 32'(Carry), 32'(e_c));
        check("overflow", 32'(Overflow), 32'(e_v));
        check("zero", 32'(Zero), 32'(e_res == '0));
        check("error", 32'(Error), 32'(e_err));
        if (!e_err) begin
            check("slice_seq", 32'(slice_err), 32'd0);
            check("cin0", 32'(cin0_obs), 32'(sub));
            check("binv0", 32'(binv0_obs), 32'(sub));
        end
        @(posedge Clock); #1;
        check("done_pulse", 32'(Done), 32'd0);
        check("slice_idle", 32'({SliceA, SliceB, SliceCIN, SliceBInvert, SliceLess, SliceCtrl}), 32'd0);
        @(posedge Clock); #1;
        check("result_hold", 32'(Result), 32'(e_res));
    endtask

    logic [W-1:0] specials [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};

    function automatic logic [W-1:0] pick();
        int s;
        s = int'($urandom_range(0, 5));
        if (s < 4) return specials[s];
        return W'($urandom);
    endfunction

    initial begin
        int done_seen;
        Reset = 1'b0; Start = 1'b0; OpCode = '0; OpA = '0; OpB = '0;
        #1;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_result", 32'(Result), 32'd0);
        check("rst_flags", 32'({Carry, Overflow, Zero, Error}), 32'd0);
        check("rst_slice", 32'({SliceA, SliceB, SliceCIN, SliceBInvert, SliceLess, SliceCtrl}), 32'd0);
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;

        run_op(3'b010, 16'h7FFF, 16'h0001, 1'b0);
        run_op(3'b110, 16'h0005, 16'h0005, 1'b0);
        run_op(3'b111, 16'hFFFE, 16'h0003, 1'b0);
        run_op(3'b111, 16'h0003, 16'hFFFE, 1'b0);
        run_op(3'b000, 16'hA5F0, 16'h0FF0, 1'b0);
        run_op(3'b001, 16'hA5F0, 16'h0FF0, 1'b0);
        run_op(3'b011, 16'hA5F0, 16'h0FF0, 1'b0);
        run_op(3'b101, 16'h1234, 16'h5678, 1'b0);

        // Start held high through RUN with operands changing underneath
        run_op(3'b010, 16'h1234, 16'h4321, 1'b1);
        done_seen = 0;
        repeat (4) begin
            @(posedge Clock); #1;
            if (Done) done_seen++;
        end
        check("no_requeue", 32'(done_seen), 32'd0);

        // Reset during RUN cycle 8 discards the operation
        run_op(3'b011, 16'hA5F0, 16'h0FF0, 1'b0);
        @(negedge Clock);
        Start = 1'b1; OpCode = 3'b010; OpA = 16'h1234; OpB = 16'h1111;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (8) @(posedge Clock);
        #2;
        check("busy_before_rst", 32'(Busy), 32'd1);
        Reset = 1'b0;
        #1;
        check("rst_mid_busy", 32'(Busy), 32'd0);
        check("rst_mid_done", 32'(Done), 32'd0);
        check("rst_mid_result", 32'(Result), 32'd0);
        check("rst_mid_flags", 32'({Carry, Overflow, Zero, Error}), 32'd0);
        check("rst_mid_slice", 32'({SliceA, SliceB, SliceCIN, SliceBInvert, SliceCtrl}), 32'd0);
        done_seen = 0;
        repeat (3) begin
            @(posedge Clock); #1;
            if (Done) done_seen++;
        end
        Reset = 1'b1;
        check("rst_no_done", 32'(done_seen), 32'd0);
        run_op(3'b010, 16'h0001, 16'h0001, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
